// File: rtl/seg7_scan.sv
// Multiplexed 7-segment scanner: time-slices DIGITS hex nibbles onto one shared decoder.
// Define SEG7_SCAN_LZB_EN to blank leading zeros on digits above digit 0.

module seg7 (
    input  logic [3:0] nib_i,
    output logic [6:0] seg_c
);
    // Hex encoding, bit0=a .. bit6=g, 1=lit
    always_comb begin
        seg_c = 7'b0000000;
        case (nib_i)
            4'h0: seg_c = 7'b0111111;
            4'h1: seg_c = 7'b0000110;
            4'h2: seg_c = 7'b1011011;
            4'h3: seg_c = 7'b1001111;
            4'h4: seg_c = 7'b1100110;
            4'h5: seg_c = 7'b1101101;
            4'h6: seg_c = 7'b1111101;
            4'h7: seg_c = 7'b0000111;
            4'h8: seg_c = 7'b1111111;
            4'h9: seg_c = 7'b1101111;
            4'hA: seg_c = 7'b1110111;
            4'hB: seg_c = 7'b1111100;
            4'hC: seg_c = 7'b0111001;
            4'hD: seg_c = 7'b1011110;
            4'hE: seg_c = 7'b1111001;
            4'hF: seg_c = 7'b1110001;
            default: seg_c = 7'b0000000;
        endcase
    end
endmodule

module seg7_scan #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DWELL  = 1000,
    parameter int unsigned GUARD  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig,
    output logic                  frame_done
);
    localparam int unsigned DW   = 4 * DIGITS;
    localparam int unsigned MAXC = (DWELL > GUARD) ? DWELL : GUARD;
    localparam int unsigned CW   = $clog2(MAXC + 1);
    localparam int unsigned IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {S_OFF, S_DRIVE, S_GUARD} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DW-1:0]       val_q, val_d;
    logic [DW-1:0]       pend_q, pend_d;
    logic                pend_vld_q, pend_vld_d;
    logic                in_ready_q, in_ready_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   dig_q, dig_d;
    logic                frame_done_q, frame_done_d;
    logic                step_c;
    logic                accept_c;
    logic [3:0]          nib_c;
    logic                blank_c;
    logic [6:0]          seg_dec_c;

    assign in_ready   = in_ready_q;
    assign seg        = seg_q;
    assign dig        = dig_q;
    assign frame_done = frame_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_OFF;
            idx_q        <= '0;
            cnt_q        <= '0;
            val_q        <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            in_ready_q   <= 1'b1;
            seg_q        <= '0;
            dig_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            val_q        <= val_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            in_ready_q   <= in_ready_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Scan sequencing and the pending/displayed value handshake
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        val_d        = val_q;
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;
        frame_done_d = 1'b0;
        step_c       = 1'b0;
        accept_c     = in_valid && in_ready_q;

        if (!enable) begin
            state_d = S_OFF;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    state_d = S_DRIVE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                S_DRIVE: begin
                    if (cnt_q == CW'(DWELL - 1)) begin
                        cnt_d = '0;
                        if (GUARD > 0) begin
                            state_d = S_GUARD;
                        end else begin
                            step_c = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_GUARD: begin
                    if (cnt_q == CW'(GUARD - 1)) begin
                        cnt_d   = '0;
                        state_d = S_DRIVE;
                        step_c  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = S_OFF;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        if (step_c) begin
            if (idx_q == IW'(DIGITS - 1)) begin
                idx_d        = '0;
                frame_done_d = 1'b1;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end

        // Swap in a new value only between frames so a scan never mixes two values
        if (pend_vld_q && (frame_done_d || state_q == S_OFF)) begin
            val_d      = pend_q;
            pend_vld_d = 1'b0;
        end
        if (accept_c) begin
            pend_d     = in_data;
            pend_vld_d = 1'b1;
        end
        in_ready_d = !(pend_vld_q || accept_c);
    end

    // Nibble for the digit being driven next cycle, plus leading-zero blanking
    always_comb begin
        nib_c   = 4'h0;
        blank_c = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_d == IW'(i)) nib_c = val_d[4*i +: 4];
        end
`ifdef SEG7_SCAN_LZB_EN
        begin
            logic lz;
            lz = 1'b1;
            for (int i = int'(DIGITS) - 1; i > 0; i--) begin
                lz = lz && (val_d[4*i +: 4] == 4'h0);
                if (idx_d == IW'(i)) blank_c = lz;
            end
        end
`endif
    end

    seg7 u_seg7 (
        .nib_i (nib_c),
        .seg_c (seg_dec_c)
    );

    // seg and dig both derive from next state so they always flip on the same edge
    always_comb begin
        seg_d = '0;
        dig_d = '0;
        if (state_d == S_DRIVE) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                dig_d[i] = (idx_d == IW'(i));
            end
            seg_d = blank_c ? 7'b0000000 : seg_dec_c;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: DIGITS=4, DWELL=4, with GUARD=1 and GUARD=0 instances.

module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready,    in_ready_g0;
    logic [6:0]  seg,         seg_g0;
    logic [3:0]  dig,         dig_g0;
    logic        frame_done,  frame_done_g0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] t1234 [4];
    logic [6:0] tabcd [4];
    logic [6:0] t0050 [4];

    always #5 clk = ~clk;

    seg7_scan #(.DIGITS(4), .DWELL(4), .GUARD(1)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .seg        (seg),
        .dig        (dig),
        .frame_done (frame_done)
    );

    seg7_scan #(.DIGITS(4), .DWELL(4), .GUARD(0)) u_dut_g0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_ready   (in_ready_g0),
        .in_data    (in_data),
        .seg        (seg_g0),
        .dig        (dig_g0),
        .frame_done (frame_done_g0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Load a value while the scanner is OFF: ready drops, commit, ready returns
    task automatic load_off(input logic [15:0] v);
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        check("load rdy_drop", 32'(in_ready), 32'(0));
        in_valid = 1'b0;
        in_data  = 16'hFFFF;
        @(negedge clk);
        check("load rdy_commit", 32'(in_ready), 32'(0));
        check("load dark", 32'(dig), 32'(0));
        @(negedge clk);
        check("load rdy_back", 32'(in_ready), 32'(1));
    endtask

    initial begin
        logic [3:0] one;
        logic [3:0] exp_dig;
        logic [6:0] exp_seg;
        int d, r;

        one   = 4'b0001;
        t1234 = '{7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110};
        tabcd = '{7'b1011110, 7'b0111001, 7'b1111100, 7'b1110111};
`ifdef SEG7_SCAN_LZB_EN
        t0050 = '{7'b0111111, 7'b1101101, 7'b0000000, 7'b0000000};
`else
        t0050 = '{7'b0111111, 7'b1101101, 7'b0111111, 7'b0111111};
`endif

        rst_n    = 1'b1;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'h0000;
        #2 rst_n = 1'b0;
        #1;
        check("rst seg", 32'(seg), 32'(0));
        check("rst dig", 32'(dig), 32'(0));
        check("rst fd", 32'(frame_done), 32'(0));
        check("rst rdy", 32'(in_ready), 32'(1));
        check("rst rdy_g0", 32'(in_ready_g0), 32'(1));
        @(negedge clk);
        check("rst hold dig", 32'(dig), 32'(0));
        check("rst hold rdy", 32'(in_ready), 32'(1));
        rst_n = 1'b1;
        @(negedge clk);
        check("off dig", 32'(dig), 32'(0));

        load_off(16'h1234);
        enable = 1'b1;

        // Steady scan of 1234, mid-frame load of ABCD, then disable during digit 2
        for (int k = 0; k < 72; k++) begin
            @(negedge clk);
            d = (k % 20) / 5;
            r = (k % 20) % 5;
            exp_dig = (r < 4) ? (one << d) : 4'b0000;
            exp_seg = (r < 4) ? ((k >= 40) ? tabcd[d] : t1234[d]) : 7'b0000000;
            check($sformatf("scan dig k=%0d", k), 32'(dig), 32'(exp_dig));
            check($sformatf("scan seg k=%0d", k), 32'(seg), 32'(exp_seg));
            check($sformatf("scan fd k=%0d", k), 32'(frame_done),
                  32'((k == 20) || (k == 40) || (k == 60)));
            check($sformatf("scan rdy k=%0d", k), 32'(in_ready),
                  32'(!((k >= 24) && (k <= 40))));
            if (k == 23) begin in_valid = 1'b1; in_data = 16'hABCD; end
            if (k == 24) begin in_valid = 1'b0; in_data = 16'h0000; end
            if (k == 30) begin in_valid = 1'b1; in_data = 16'h9999; end
            if (k == 31) begin in_valid = 1'b0; end
            if (k == 71) enable = 1'b0;
        end

        @(negedge clk);
        check("dis dig", 32'(dig), 32'(0));
        check("dis seg", 32'(seg), 32'(0));
        @(negedge clk);
        check("dis dig2", 32'(dig), 32'(0));
        check("dis fd", 32'(frame_done), 32'(0));
        enable = 1'b1;

        // Restart from digit 0 with a full dwell; reset pulsed inside the guard slot
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("re dig k=%0d", k), 32'(dig), 32'((k < 4) ? 4'b0001 : 4'b0000));
            check($sformatf("re seg k=%0d", k), 32'(seg), 32'((k < 4) ? tabcd[0] : 7'b0000000));
            check($sformatf("re rdy k=%0d", k), 32'(in_ready), 32'(k < 2));
            if (k == 1) begin in_valid = 1'b1; in_data = 16'h5555; end
            if (k == 2) in_valid = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst seg", 32'(seg), 32'(0));
        check("arst dig", 32'(dig), 32'(0));
        check("arst rdy", 32'(in_ready), 32'(1));
        check("arst fd", 32'(frame_done), 32'(0));
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post rst dig", 32'(dig), 32'(4'b0001));
        check("post rst seg", 32'(seg), 32'(7'b0111111));
        check("post rst rdy", 32'(in_ready), 32'(1));

        enable = 1'b0;
        @(negedge clk);
        check("off2 dig", 32'(dig), 32'(0));
        check("off2 dig_g0", 32'(dig_g0), 32'(0));
        load_off(16'h0050);
        enable = 1'b1;

        // 0050 on both instances: guard vs no-guard timing and leading-zero display
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            d = (k % 20) / 5;
            r = (k % 20) % 5;
            exp_dig = (r < 4) ? (one << d) : 4'b0000;
            exp_seg = (r < 4) ? t0050[d] : 7'b0000000;
            check($sformatf("lz dig k=%0d", k), 32'(dig), 32'(exp_dig));
            check($sformatf("lz seg k=%0d", k), 32'(seg), 32'(exp_seg));
            check($sformatf("lz fd k=%0d", k), 32'(frame_done), 32'(k == 20));
            d = (k % 16) / 4;
            check($sformatf("g0 dig k=%0d", k), 32'(dig_g0), 32'(one << d));
            check($sformatf("g0 seg k=%0d", k), 32'(seg_g0), 32'(t0050[d]));
            check($sformatf("g0 fd k=%0d", k), 32'(frame_done_g0), 32'(k == 16));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter DWELL, default 1000, clock cycles each digit is driven (legal >=1).
REQ-003 SHALL have parameter GUARD, default 8, blanking cycles between digits (legal >=0).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port enable  input  1  scan enable; 0 forces display dark.
REQ-007 SHALL have port in_valid  input  1  new display value offered.
REQ-008 SHALL have port in_ready  output  1  block can accept a value.
REQ-009 SHALL have port in_data  input  4*DIGITS  hex nibbles, nibble i shown on digit i.
REQ-010 SHALL have port seg  output  7  segment drive, bit0=a(top) .. bit6=g(middle), 1=lit.
REQ-011 SHALL have port dig  output  DIGITS  one-hot digit select, 1=digit on.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at end of each full scan.

Function
REQ-013 SHALL decode nibbles through one shared seg7 instance (team standard hex encoding, 0 -> 7'b0111111, F -> 7'b1110001).
REQ-014 SHALL register seg and dig so that they change on the same clock edge; dig and seg never disagree in any cycle.
REQ-015 SHALL implement FSM states OFF, DRIVE, GUARD plus digit index idx (0..DIGITS-1).
REQ-016 SHALL in OFF drive dig=0, seg=0, idx=0, counters cleared; OFF -> DRIVE(idx 0) when enable=1.
REQ-017 SHALL in DRIVE assert dig=1<<idx and seg=decode(val[4*idx+:4]) for exactly DWELL cycles.
REQ-018 SHALL after DRIVE enter GUARD for exactly GUARD cycles with dig=0, seg=0; GUARD=0 skips GUARD entirely (DRIVE -> DRIVE(idx+1)).
REQ-019 SHALL after GUARD advance idx by 1, wrapping DIGITS-1 -> 0; frame length = DIGITS*(DWELL+GUARD) cycles.
REQ-020 SHALL pulse frame_done for one cycle on the cycle the final post-digit-(DIGITS-1) interval ends (same edge idx wraps to 0).
REQ-021 SHALL move to OFF on the edge after enable falls, from any state, mid-digit included.
REQ-022 SHALL accept in_data when in_valid && in_ready into a pending register and drop in_ready to 0 the next cycle.
REQ-023 SHALL commit pending to displayed value val at the frame_done edge (no mid-frame tearing) and raise in_ready the following cycle.
REQ-024 SHALL, while in OFF, commit a pending value on the next edge and raise in_ready one cycle later.
REQ-025 SHALL ignore in_valid while in_ready=0; in_data may change freely then.
REQ-026 SHALL size counters to $clog2 of max(DWELL,GUARD)+1 bits; no counter may wrap outside its defined terminal count.

Reset
REQ-027 SHALL on rst_n=0 asynchronously force state=OFF, idx=0, counters=0, val=0, pending empty.
REQ-028 SHALL hold during reset: seg=0, dig=0, frame_done=0, in_ready=1.
REQ-029 SHALL on rst_n release begin in OFF; if enable=1, DRIVE(idx 0) starts on the first rising edge.

Configuration
REQ-030 SHALL, with macro SEG7_SCAN_LZB_EN defined, blank leading zeros: digit i>0 drives seg=0 (dig still asserted, timing unchanged) when all nibbles i..DIGITS-1 of val are 0.
REQ-031 SHALL never blank digit 0 under SEG7_SCAN_LZB_EN (val=0 shows a single "0").
REQ-032 SHALL, without SEG7_SCAN_LZB_EN, display every nibble including leading zeros; no extra logic present.

Verification (DIGITS=4, DWELL=4, GUARD=1 unless noted)
REQ-033 SHALL check: reset, enable=1, load 16'h1234 while OFF -> dig=0001 seg=7'b1100110 for 4 cycles, 1 dark cycle, dig=0010 seg=7'b1001111, ..., frame_done every 20 cycles.
REQ-034 SHALL check: load 16'hABCD mid-frame -> in_ready=0 next cycle, displayed digits stay 1234 until frame_done edge, digit0 then shows 7'b1011110, in_ready=1 one cycle later.
REQ-035 SHALL check: enable dropped during DRIVE of digit 2 -> next cycle dig=0 seg=0; re-enable -> restarts at dig=0001 with full 4-cycle dwell.
REQ-036 SHALL check: rst_n pulsed low mid-GUARD without a clock edge -> seg=0, dig=0, in_ready=1 immediately; val reads 0 after release.
REQ-037 SHALL check: GUARD=0 -> no dark cycles, dig steps 0001,0010,0100,1000 every 4 cycles, frame 16 cycles.
REQ-038 SHALL check: SEG7_SCAN_LZB_EN, val=16'h0050 -> digits 3,2 seg=0 with dig asserted, digit1 7'b1101101, digit0 7'b0111111; undefined macro -> digit3 shows 7'b0111111.
